alu_share_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing the single combinational 4-bit ALU among NUM_REQ requesters.

---
 rtl/alu_share_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_share_arbiter                                             |
// | Purpose  : Round-robin arbiter/sequencer that shares one combinational   |
// |            4-bit ALU among NUM_REQ requesters. A granted {op,a,b} is     |
// |            latched, driven to the ALU for one cycle, and the registered  |
// |            8-bit result and zero flag are returned over a valid/ready    |
// |            handshake tagged with the owning requester id.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, reset              clock; synchronous active-high reset           |
// |   req_valid/op/a/b        per-requester request, 4-bit fields packed     |
// |                           with requester i at [4i+3:4i]                  |
// |   req_ready               one-hot grant, only ever high in IDLE          |
// |   alu_control/in1/in2     drive to the shared ALU (zero outside EXEC)    |
// |   alu_result, alu_zero    combinational ALU outputs                      |
// |   rsp_valid/ready         response handshake                             |
// |   rsp_data/zero/id        registered result, zero flag, owner id         |
// |   busy                    high whenever the sequencer is not IDLE        |
// |   timeout_err             one-cycle pulse when a response is dropped     |
// | Configuration                                                            |
// |   ALU_ARB_RSP_TIMEOUT_EN  defined: responses left unaccepted for         |
// |                           TIMEOUT_CYCLES RESP cycles are dropped.        |
// |                           undefined: RESP waits forever, timeout_err=0.  |
// +--------------------------------------------------------------------------+
module alu_share_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_op,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [3:0]           alu_control,
  output logic [3:0]           alu_in1,
  output logic [3:0]           alu_in2,
  input  logic [7:0]           alu_result,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_data,
  output logic                 rsp_zero,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy,
  output logic                 timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("ID_W must equal clog2(NUM_REQ)");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  localparam logic [ID_W:0]   c_num_req = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_id;
  logic [3:0]      r_op;
  logic [3:0]      r_a;
  logic [3:0]      r_b;
  logic [7:0]      r_data;
  logic            r_zero;

  logic [2*NUM_REQ-1:0] w_dbl;
  logic                 w_any;
  logic [ID_W:0]        w_off;
  logic [ID_W:0]        w_sum;
  logic [ID_W-1:0]      w_winner;
  logic [3:0]           w_sel_op;
  logic [3:0]           w_sel_a;
  logic [3:0]           w_sel_b;
  logic                 w_grant;
  logic                 w_release;
  logic                 w_to_hit;
  logic [ID_W-1:0]      w_id_inc;

  // Rotate the request vector so that bit 0 is the requester at rr_ptr; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    w_dbl = {req_valid, req_valid} >> r_rr_ptr;
    w_any = |req_valid;
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_dbl[i]) begin
        w_off = i[ID_W:0];
      end
    end
    w_sum    = {1'b0, r_rr_ptr} + w_off;
    w_winner = (w_sum >= c_num_req) ? ID_W'(w_sum - c_num_req) : w_sum[ID_W-1:0];
  end

  always_comb begin
    w_sel_op  = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == i[ID_W-1:0]) begin
        w_sel_op     = req_op[4*i +: 4];
        w_sel_a      = req_a[4*i +: 4];
        w_sel_b      = req_b[4*i +: 4];
        req_ready[i] = w_grant;
      end
    end
  end

  assign w_grant  = !reset && (r_state == ST_IDLE) && w_any;
  assign w_id_inc = (r_id == c_last_id) ? '0 : r_id + 1'b1;

  // Next-state logic; a response leaves RESP either by accept or by drop.
  always_comb begin
    w_state_nxt = r_state;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready || w_to_hit) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_data   <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_any) begin
        r_id <= w_winner;
        r_op <= w_sel_op;
        r_a  <= w_sel_a;
        r_b  <= w_sel_b;
      end
      if (r_state == ST_EXEC) begin
        r_data <= alu_result;
        r_zero <= alu_zero;
      end
      if (w_release) begin
        r_rr_ptr <= w_id_inc;
      end
    end
  end

`ifdef ALU_ARB_RSP_TIMEOUT_EN
  localparam logic [7:0] c_to_last = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_wait;
  logic       r_timeout_err;

  // Counter sits at zero outside RESP, so it is clear on every RESP entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= (r_state == ST_RESP) && !rsp_ready && w_to_hit;
      if (r_state != ST_RESP) begin
        r_wait <= '0;
      end else if (!rsp_ready) begin
        r_wait <= r_wait + 8'd1;
      end
    end
  end

  assign w_to_hit    = (r_wait == c_to_last);
  assign timeout_err = r_timeout_err;
`else
  assign w_to_hit    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Combinational outputs are forced low while reset is asserted so that the
  // block is silent for the whole reset window, not only after the first edge.
  assign alu_control = (!reset && r_state == ST_EXEC) ? r_op : 4'd0;
  assign alu_in1     = (!reset && r_state == ST_EXEC) ? r_a  : 4'd0;
  assign alu_in2     = (!reset && r_state == ST_EXEC) ? r_b  : 4'd0;
  assign rsp_valid   = !reset && (r_state == ST_RESP);
  assign busy        = !reset && (r_state != ST_IDLE);
  assign rsp_data    = r_data;
  assign rsp_zero    = r_zero;
  assign rsp_id      = r_id;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_share_arbiter                                          |
// | Purpose  : Scoreboard bench for alu_share_arbiter with a behavioural ALU |
// |            and a round-robin reference model.                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu_share_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 4;
`ifdef ALU_ARB_RSP_TIMEOUT_EN
  localparam int HOLD = 2;
`else
  localparam int HOLD = 6;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_op, req_a, req_b;
  logic [N-1:0]   req_ready;
  logic [3:0]     alu_control, alu_in1, alu_in2;
  logic [7:0]     alu_result;
  logic           alu_zero;
  logic           rsp_valid, rsp_ready;
  logic [7:0]     rsp_data;
  logic           rsp_zero;
  logic [IW-1:0]  rsp_id;
  logic           busy, timeout_err;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .alu_control(alu_control), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_id(rsp_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Behavioural stand-in for the processor ALU.
  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] x, y;
    x = {4'd0, a};
    y = {4'd0, b};
    case (op)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x ^ y;
      4'd3:  return {4'd0, ~a};
      4'd4:  return x << 1;
      4'd5:  return x >> 1;
      4'd6:  return x + y;
      4'd7:  return x - y;
      4'd8:  return x * y;
      4'd9:  return (b == 4'd0) ? 8'hFF : x / y;
      4'd10: return (b == 4'd0) ? x : x % y;
      4'd11: return (a < b) ? 8'd1 : 8'd0;
      4'd12: return (a == b) ? 8'd1 : 8'd0;
      4'd13: return {a, b};
      4'd14: return {b, a};
      default: return x + 8'd1;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_ref(alu_control, alu_in1, alu_in2);
    alu_zero   = (alu_result == 8'd0);
  end

  typedef struct { int id; logic [7:0] data; logic zero; } exp_t;

  exp_t sb[$];
  int   glog_id[$];
  int   glog_cyc[$];
  int   checks = 0, errors = 0;
  int   next_ptr = 0, cyc = 0, cycle = 0, accepts = 0, drops = 0, wait_cnt = 0;
  bit   inflight = 0, exp_terr = 0, reset_seen = 0;
  bit   granted [N];
  logic [7:0] last_data;
  logic       last_zero;
  int         last_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Control monitor: grant selection, handshake timing, reset behaviour.
  always @(negedge clk) begin
    int w;
    logic [7:0] d;
    cycle++;
    if (reset) begin
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_alu_control", 32'(alu_control), 0);
      if (reset_seen) begin
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
      end
      reset_seen = 1;
      inflight = 0; next_ptr = 0; exp_terr = 0; wait_cnt = 0;
      sb.delete();
      for (int i = 0; i < N; i++) granted[i] = 0;
    end else begin
      reset_seen = 0;
      check("timeout_err", 32'(timeout_err), 32'(exp_terr));
      exp_terr = 0;
      if (inflight) begin
        cyc++;
        check("req_ready_busy", 32'(req_ready), 0);
        check("rsp_valid_timing", 32'(rsp_valid), 32'(cyc >= 2));
        check("busy_active", 32'(busy), 1);
      end else begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (next_ptr + k) % N;
          if (w < 0 && req_valid[j]) w = j;
        end
        check("req_ready", 32'(req_ready), (w < 0) ? 0 : (32'd1 << w));
        check("rsp_valid_idle", 32'(rsp_valid), 0);
        check("busy_idle", 32'(busy), 0);
        if (w >= 0) begin
          d = alu_ref(req_op[4*w +: 4], req_a[4*w +: 4], req_b[4*w +: 4]);
          sb.push_back('{id: w, data: d, zero: (d == 8'd0)});
          inflight = 1;
          cyc = 0;
          granted[w] = 1;
          glog_id.push_back(w);
          glog_cyc.push_back(cycle);
        end
      end
    end
  end

  // Response monitor: compares every presented response with the scoreboard.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!reset && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected id=%0d data=%0h with empty scoreboard", rsp_id, rsp_data);
      end else begin
        e = sb[0];
        check("rsp_id", 32'(rsp_id), e.id);
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
        if (rsp_ready) begin
          void'(sb.pop_front());
          next_ptr  = (e.id + 1) % N;
          inflight  = 0;
          wait_cnt  = 0;
          accepts++;
          last_data = rsp_data;
          last_zero = rsp_zero;
          last_id   = 32'(rsp_id);
        end else begin
`ifdef ALU_ARB_RSP_TIMEOUT_EN
          wait_cnt++;
          if (wait_cnt == TO) begin
            void'(sb.pop_front());
            next_ptr = (e.id + 1) % N;
            inflight = 0;
            wait_cnt = 0;
            exp_terr = 1;
            drops++;
          end
`endif
        end
      end
    end
  end

  task automatic wait_grant(input int i);
    int n = 0;
    while (!granted[i] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!granted[i]) begin
      errors++;
      $display("FAIL grant_wait requester=%0d not granted, required within 60 cycles", i);
    end
    granted[i] = 0;
    req_valid[i] = 1'b0;
  endtask

  task automatic raise(input int i, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    req_valid[i]    = 1'b1;
    req_op[4*i +: 4] = op;
    req_a[4*i +: 4]  = a;
    req_b[4*i +: 4]  = b;
  endtask

  task automatic issue(input int i, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    @(posedge clk); #1;
    raise(i, op, a, b);
    wait_grant(i);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((inflight || sb.size() != 0) && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_outstanding", 32'(sb.size()), 0);
  endtask

  initial begin
    int t0;
    reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single add from requester 0.
    rsp_ready = 1'b1;
    issue(0, 4'b0110, 4'd5, 4'd3);
    wait_idle();
    check("t1_data", 32'(last_data), 32'h08);
    check("t1_zero", 32'(last_zero), 0);
    check("t1_id", last_id, 0);

    // Zero result and divide by zero.
    issue(1, 4'b0000, 4'd4, 4'd3);
    wait_idle();
    check("t4_and_data", 32'(last_data), 0);
    check("t4_and_zero", 32'(last_zero), 1);
    issue(2, 4'b1001, 4'd7, 4'd0);
    wait_idle();
    check("t4_div0_data", 32'(last_data), 32'hFF);
    check("t4_div0_zero", 32'(last_zero), 0);

    // Back-pressured multiply with a competing requester waiting.
    rsp_ready = 1'b0;
    issue(1, 4'b1000, 4'd15, 4'd15);
    raise(3, 4'd6, 4'd1, 4'd1);
    repeat (HOLD) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_grant(3);
    check("t3_data", 32'(last_data), 32'hE1);
    wait_idle();

    // All four held high: strict rotation, one grant every 3 cycles.
    glog_id.delete(); glog_cyc.delete();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) raise(i, 4'($urandom), 4'($urandom), 4'($urandom));
    repeat (15) @(posedge clk);
    #1 req_valid = '0;
    for (int i = 0; i < N; i++) granted[i] = 0;
    wait_idle();
    check("t2_grant_count_ge5", 32'(glog_id.size() >= 5), 1);
    for (int k = 0; k < 5 && k < glog_id.size(); k++) begin
      check("t2_grant_order", glog_id[k], k % N);
      if (k > 0) check("t2_grant_spacing", glog_cyc[k] - glog_cyc[k-1], 3);
    end

    // Reset while EXEC: pointer returns to 0 and the in-flight op vanishes.
    issue(1, 4'd6, 4'd2, 4'd2);
    wait_idle();
    issue(1, 4'd6, 4'd9, 4'd9);
    reset = 1'b1;
    raise(2, 4'd1, 4'd3, 4'd4);
    raise(0, 4'd2, 4'd5, 4'd6);
    repeat (2) @(posedge clk);
    glog_id.delete(); glog_cyc.delete();
    #1 reset = 1'b0;
    wait_grant(0);
    check("t5_first_grant", (glog_id.size() > 0) ? glog_id[0] : -1, 0);
    wait_grant(2);
    wait_idle();

`ifdef ALU_ARB_RSP_TIMEOUT_EN
    // Unaccepted response is dropped and the next requester is served.
    rsp_ready = 1'b0;
    t0 = drops;
    issue(2, 4'd6, 4'd1, 4'd2);
    raise(0, 4'd6, 4'd3, 4'd3);
    wait_grant(0);
    check("t6_drop_seen", drops - t0, 1);
    rsp_ready = 1'b1;
    wait_idle();
`else
    t0 = 0;
`endif

    // Randomised traffic with random back-pressure.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (granted[i]) begin
          granted[i] = 0;
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && $urandom_range(99) < 30)
          raise(i, 4'($urandom), 4'($urandom), 4'($urandom));
      end
      rsp_ready = ($urandom_range(99) < 60);
    end

    // Drain: no new requests, let every pending one complete.
    rsp_ready = 1'b1;
    t0 = 0;
    while ((req_valid != '0 || inflight) && t0 < 400) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (granted[i]) begin
          granted[i] = 0;
          req_valid[i] = 1'b0;
        end
      end
      t0++;
    end
    check("final_pending_requests", 32'(req_valid), 0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
